raw_scoreboard: RTL and testbench

Parametrised RAW-hazard scoreboard for the multi-issue stage. It tracks the destination tags of up to DEPTH in-flight instructions in a CAM of entries. It flags a hazard for each candidate issue lane whose sources match a pending destination, or match the destination of an older lane in the same bundle. Issuing lanes allocate entries; writebacks release them; a flush clears everything.

---
 rtl/raw_scb_pkg.sv | 17 +
 rtl/raw_scoreboard_if.sv | 30 +++
 rtl/raw_scb_entry.sv | 47 ++++
 rtl/raw_scoreboard.sv | 150 +++++++++++++++
 tb/tb_raw_scoreboard.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/raw_scb_pkg.sv
// Shared constants and types for the RAW-hazard scoreboard.
package raw_scb_pkg;
   localparam int TAG_W_DEF   = 4;
   localparam int DEPTH_DEF   = 16;
   localparam int ISSUE_W_DEF = 4;
   localparam int WB_W_DEF    = 4;

   // Bit positions inside the sticky err vector
   localparam int ERR_OVF    = 0;
   localparam int ERR_ORPHAN = 1;

   // One tracking slot at the default tag width
   typedef struct packed {
      logic                 valid;
      logic [TAG_W_DEF-1:0] tag;
   } entry_t;
endpackage

// File: rtl/raw_scoreboard_if.sv
// Check / allocate / writeback bundle between the issue stage and the scoreboard.
interface raw_scoreboard_if #(
   parameter int TAG_W   = 4,
   parameter int ISSUE_W = 4,
   parameter int WB_W    = 4,
   parameter int OCC_W   = 5
);
   logic [ISSUE_W-1:0]       chk_vld;
   logic [ISSUE_W*TAG_W-1:0] chk_des;
   logic [ISSUE_W*TAG_W-1:0] chk_src1;
   logic [ISSUE_W*TAG_W-1:0] chk_src2;
   logic [ISSUE_W-1:0]       alloc_vld;
   logic [WB_W-1:0]          wb_vld;
   logic [WB_W*TAG_W-1:0]    wb_des;
   logic                     flush;
   logic [ISSUE_W-1:0]       hazard;
   logic                     full;
   logic [OCC_W-1:0]         occupancy;
   logic [1:0]               err;

   modport master (
      output chk_vld, chk_des, chk_src1, chk_src2, alloc_vld, wb_vld, wb_des, flush,
      input  hazard, full, occupancy, err
   );

   modport slave (
      input  chk_vld, chk_des, chk_src1, chk_src2, alloc_vld, wb_vld, wb_des, flush,
      output hazard, full, occupancy, err
   );
endinterface

// File: rtl/raw_scb_entry.sv
// One CAM slot: valid/tag register plus per-lane source-tag match.
module raw_scb_entry #(
   parameter int TAG_W   = 4,
   parameter int ISSUE_W = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     set_i,
   input  logic [TAG_W-1:0]         set_tag_i,
   input  logic                     clr_i,
   input  logic                     flush_i,
   input  logic [ISSUE_W*TAG_W-1:0] src1_i,
   input  logic [ISSUE_W*TAG_W-1:0] src2_i,
   output logic                     valid_o,
   output logic [TAG_W-1:0]         tag_o,
   output logic [ISSUE_W-1:0]       hit1_o,
   output logic [ISSUE_W-1:0]       hit2_o
);
   logic             valid_q;
   logic [TAG_W-1:0] tag_q;

   // Flush wins; set and clear never target the same slot in one cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
      end else if (flush_i) begin
         valid_q <= 1'b0;
      end else if (set_i) begin
         valid_q <= 1'b1;
         tag_q   <= set_tag_i;
      end else if (clr_i) begin
         valid_q <= 1'b0;
      end
   end

   // Compare every lane's sources against the held tag
   always_comb begin
      for (int i = 0; i < ISSUE_W; i++) begin
         hit1_o[i] = valid_q && (tag_q == src1_i[i*TAG_W +: TAG_W]);
         hit2_o[i] = valid_q && (tag_q == src2_i[i*TAG_W +: TAG_W]);
      end
   end

   assign valid_o = valid_q;
   assign tag_o   = tag_q;
endmodule

// File: rtl/raw_scoreboard.sv
// RAW-hazard scoreboard top: slot allocation, writeback release, hazard flags,
// occupancy and sticky error tracking.
// Optional build macro RAW_SCB_BYPASS_EN: a same-cycle writeback of the only
// pending copy of a tag suppresses the hazard on that tag.
module raw_scoreboard
   import raw_scb_pkg::*;
#(
   parameter int TAG_W   = TAG_W_DEF,
   parameter int DEPTH   = DEPTH_DEF,
   parameter int ISSUE_W = ISSUE_W_DEF,
   parameter int WB_W    = WB_W_DEF,
   localparam int OCC_W  = $clog2(DEPTH+1)
) (
   input  logic             clk,
   input  logic             rst,
   raw_scoreboard_if.slave  bus
);
   logic [DEPTH-1:0]   ent_vld;
   logic [TAG_W-1:0]   ent_tag [DEPTH];
   logic [ISSUE_W-1:0] hit1 [DEPTH];
   logic [ISSUE_W-1:0] hit2 [DEPTH];

   logic [DEPTH-1:0]   set_vec, rel_vec, valid_d;
   logic [TAG_W-1:0]   set_tag [DEPTH];
   logic               ovf, orphan, found;
   logic [OCC_W-1:0]   occ_d, occ_q;
   logic               full_d, full_q;
   logic [1:0]         err_d, err_q;

   for (genvar e = 0; e < DEPTH; e++) begin : g_ent
      raw_scb_entry #(.TAG_W(TAG_W), .ISSUE_W(ISSUE_W)) u_ent (
         .clk       (clk),
         .rst       (rst),
         .set_i     (set_vec[e]),
         .set_tag_i (set_tag[e]),
         .clr_i     (rel_vec[e]),
         .flush_i   (bus.flush),
         .src1_i    (bus.chk_src1),
         .src2_i    (bus.chk_src2),
         .valid_o   (ent_vld[e]),
         .tag_o     (ent_tag[e]),
         .hit1_o    (hit1[e]),
         .hit2_o    (hit2[e])
      );
   end

   // Allocation into pre-edge free slots and release of pre-edge valid slots
   always_comb begin
      set_vec = '0;
      rel_vec = '0;
      ovf     = 1'b0;
      orphan  = 1'b0;
      found   = 1'b0;
      for (int e = 0; e < DEPTH; e++) set_tag[e] = '0;

      for (int i = 0; i < ISSUE_W; i++) begin
         if (bus.alloc_vld[i] && bus.chk_vld[i]) begin
            found = 1'b0;
            for (int e = 0; e < DEPTH; e++) begin
               if (!found && !ent_vld[e] && !set_vec[e]) begin
                  set_vec[e] = 1'b1;
                  set_tag[e] = bus.chk_des[i*TAG_W +: TAG_W];
                  found      = 1'b1;
               end
            end
            if (!found) ovf = 1'b1;
         end
      end

      for (int w = 0; w < WB_W; w++) begin
         if (bus.wb_vld[w]) begin
            found = 1'b0;
            for (int e = 0; e < DEPTH; e++) begin
               if (!found && ent_vld[e] && !rel_vec[e] &&
                   ent_tag[e] == bus.wb_des[w*TAG_W +: TAG_W]) begin
                  rel_vec[e] = 1'b1;
                  found      = 1'b1;
               end
            end
            if (!found) orphan = 1'b1;
         end
      end
   end

   // Per-lane hazard: pending-slot match or older same-bundle destination
   always_comb begin
      logic [DEPTH-1:0] m1, m2;
      logic [TAG_W-1:0] s1, s2;
      logic             intra;
`ifdef RAW_SCB_BYPASS_EN
      logic             wbh1, wbh2;
`endif
      bus.hazard = '0;
      for (int i = 0; i < ISSUE_W; i++) begin
         s1    = bus.chk_src1[i*TAG_W +: TAG_W];
         s2    = bus.chk_src2[i*TAG_W +: TAG_W];
         intra = 1'b0;
         for (int e = 0; e < DEPTH; e++) begin
            m1[e] = hit1[e][i];
            m2[e] = hit2[e][i];
         end
         for (int j = 0; j < i; j++) begin
            if (bus.chk_vld[j] && (s1 == bus.chk_des[j*TAG_W +: TAG_W] ||
                                   s2 == bus.chk_des[j*TAG_W +: TAG_W]))
               intra = 1'b1;
         end
`ifdef RAW_SCB_BYPASS_EN
         wbh1 = 1'b0;
         wbh2 = 1'b0;
         for (int w = 0; w < WB_W; w++) begin
            if (bus.wb_vld[w] && bus.wb_des[w*TAG_W +: TAG_W] == s1) wbh1 = 1'b1;
            if (bus.wb_vld[w] && bus.wb_des[w*TAG_W +: TAG_W] == s2) wbh2 = 1'b1;
         end
         if (wbh1 && $onehot(m1)) m1 = '0;
         if (wbh2 && $onehot(m2)) m2 = '0;
`endif
         bus.hazard[i] = bus.chk_vld[i] & ((|m1) | (|m2) | intra);
      end
   end

   // Post-edge slot state, occupancy, full and error accumulation
   always_comb begin
      valid_d = bus.flush ? '0 : ((ent_vld & ~rel_vec) | set_vec);
      occ_d   = '0;
      for (int e = 0; e < DEPTH; e++) occ_d = occ_d + OCC_W'(valid_d[e]);
      full_d  = (DEPTH - int'(occ_d)) < ISSUE_W;
      err_d   = err_q;
      if (!bus.flush) begin
         err_d[ERR_OVF]    = err_q[ERR_OVF]    | ovf;
         err_d[ERR_ORPHAN] = err_q[ERR_ORPHAN] | orphan;
      end
   end

   // Registered status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_q  <= '0;
         full_q <= (DEPTH < ISSUE_W);
         err_q  <= 2'b00;
      end else begin
         occ_q  <= occ_d;
         full_q <= full_d;
         err_q  <= err_d;
      end
   end

   assign bus.occupancy = occ_q;
   assign bus.full      = full_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_raw_scoreboard.sv
// Directed bench for raw_scoreboard: vector table plus async-reset sequence.
module tb_raw_scoreboard;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   raw_scoreboard_if #(.TAG_W(4), .ISSUE_W(4), .WB_W(4), .OCC_W(5)) bus ();

   raw_scoreboard #(.TAG_W(4), .DEPTH(16), .ISSUE_W(4), .WB_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [3:0]  chk_vld;
      logic [15:0] des;
      logic [15:0] src1;
      logic [15:0] src2;
      logic [3:0]  alloc;
      logic [3:0]  wb_vld;
      logic [15:0] wb_des;
      logic        flush;
      logic [3:0]  exp_haz;
      logic [4:0]  exp_occ;
      logic        exp_full;
      logic [1:0]  exp_err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic [3:0] cv, logic [15:0] d, logic [15:0] s1,
                               logic [15:0] s2, logic [3:0] al, logic [3:0] wv,
                               logic [15:0] wd, logic fl, logic [3:0] hz,
                               logic [4:0] oc, logic fu, logic [1:0] er);
      vec_t v;
      v.chk_vld = cv; v.des = d; v.src1 = s1; v.src2 = s2; v.alloc = al;
      v.wb_vld = wv; v.wb_des = wd; v.flush = fl; v.exp_haz = hz;
      v.exp_occ = oc; v.exp_full = fu; v.exp_err = er;
      return v;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_idle();
      bus.chk_vld = '0; bus.chk_des = '0; bus.chk_src1 = '0; bus.chk_src2 = '0;
      bus.alloc_vld = '0; bus.wb_vld = '0; bus.wb_des = '0; bus.flush = 1'b0;
   endtask

   task automatic apply(int idx, vec_t v);
      @(negedge clk);
      bus.chk_vld = v.chk_vld; bus.chk_des = v.des; bus.chk_src1 = v.src1;
      bus.chk_src2 = v.src2; bus.alloc_vld = v.alloc; bus.wb_vld = v.wb_vld;
      bus.wb_des = v.wb_des; bus.flush = v.flush;
      #1;
      check($sformatf("v%0d hazard", idx), 32'(bus.hazard), 32'(v.exp_haz));
      @(posedge clk);
      #1;
      check($sformatf("v%0d occupancy", idx), 32'(bus.occupancy), 32'(v.exp_occ));
      check($sformatf("v%0d full", idx), 32'(bus.full), 32'(v.exp_full));
      check($sformatf("v%0d err", idx), 32'(bus.err), 32'(v.exp_err));
   endtask

   initial begin
      logic [3:0] byp_haz;
`ifdef RAW_SCB_BYPASS_EN
      byp_haz = 4'b0000;
`else
      byp_haz = 4'b0001;
`endif
      //            chk    des      src1     src2     alloc  wbv    wbdes    fl  haz    occ fu err
      vecs.push_back(mk(4'h0, 16'h0000, 16'h0000, 16'h0000, 4'h0, 4'h0, 16'h0000, 0, 4'h0, 0,  0, 2'b00));
      vecs.push_back(mk(4'h1, 16'h0005, 16'h0000, 16'h0000, 4'h1, 4'h0, 16'h0000, 0, 4'h0, 1,  0, 2'b00));
      vecs.push_back(mk(4'h2, 16'h0000, 16'h0050, 16'h0000, 4'h0, 4'h0, 16'h0000, 0, 4'h2, 1,  0, 2'b00));
      vecs.push_back(mk(4'h5, 16'h0003, 16'h0000, 16'h0300, 4'h0, 4'h0, 16'h0000, 0, 4'h4, 1,  0, 2'b00));
      vecs.push_back(mk(4'h0, 16'h0000, 16'h0000, 16'h0000, 4'h0, 4'h0, 16'h0000, 1, 4'h0, 0,  0, 2'b00));
      vecs.push_back(mk(4'hF, 16'h4321, 16'h0000, 16'h0000, 4'hF, 4'h0, 16'h0000, 0, 4'h0, 4,  0, 2'b00));
      vecs.push_back(mk(4'hF, 16'h4321, 16'h0000, 16'h0000, 4'hF, 4'h0, 16'h0000, 0, 4'h0, 8,  0, 2'b00));
      vecs.push_back(mk(4'hF, 16'h4321, 16'h0000, 16'h0000, 4'hF, 4'h0, 16'h0000, 0, 4'h0, 12, 0, 2'b00));
      vecs.push_back(mk(4'hF, 16'h4321, 16'h0000, 16'h0000, 4'hF, 4'h0, 16'h0000, 0, 4'h0, 16, 1, 2'b00));
      vecs.push_back(mk(4'h1, 16'h0001, 16'h0000, 16'h0000, 4'h1, 4'h0, 16'h0000, 0, 4'h0, 16, 1, 2'b01));
      vecs.push_back(mk(4'h0, 16'h0000, 16'h0000, 16'h0000, 4'h0, 4'h0, 16'h0000, 1, 4'h0, 0,  0, 2'b01));
      vecs.push_back(mk(4'h3, 16'h0077, 16'h0000, 16'h0000, 4'h3, 4'h0, 16'h0000, 0, 4'h0, 2,  0, 2'b01));
      vecs.push_back(mk(4'h1, 16'h0000, 16'h0007, 16'h0000, 4'h0, 4'h3, 16'h0077, 0, 4'h1, 0,  0, 2'b01));
      vecs.push_back(mk(4'h1, 16'h0000, 16'h0007, 16'h0000, 4'h0, 4'h0, 16'h0000, 0, 4'h0, 0,  0, 2'b01));
      vecs.push_back(mk(4'h0, 16'h0000, 16'h0000, 16'h0000, 4'h0, 4'h1, 16'h0007, 0, 4'h0, 0,  0, 2'b11));
      vecs.push_back(mk(4'h1, 16'h0009, 16'h0000, 16'h0000, 4'h1, 4'h0, 16'h0000, 0, 4'h0, 1,  0, 2'b11));
      vecs.push_back(mk(4'h1, 16'h0000, 16'h0009, 16'h0000, 4'h0, 4'h1, 16'h0009, 0, byp_haz, 0, 0, 2'b11));
      vecs.push_back(mk(4'h1, 16'h0006, 16'h0000, 16'h0000, 4'h1, 4'h0, 16'h0000, 0, 4'h0, 1,  0, 2'b11));
      vecs.push_back(mk(4'h1, 16'h0006, 16'h0000, 16'h0000, 4'h1, 4'h1, 16'h0006, 0, 4'h0, 1,  0, 2'b11));
      vecs.push_back(mk(4'h2, 16'h0000, 16'h0060, 16'h0000, 4'h0, 4'h0, 16'h0000, 0, 4'h2, 1,  0, 2'b11));
      vecs.push_back(mk(4'hF, 16'hAAAA, 16'h0000, 16'h0000, 4'hF, 4'h0, 16'h0000, 0, 4'h0, 5,  0, 2'b11));
      vecs.push_back(mk(4'hF, 16'hAAAA, 16'h0000, 16'h0000, 4'hF, 4'h0, 16'h0000, 0, 4'h0, 9,  0, 2'b11));
      vecs.push_back(mk(4'h1, 16'h000A, 16'h0000, 16'h0000, 4'h1, 4'h0, 16'h0000, 0, 4'h0, 10, 0, 2'b11));
      vecs.push_back(mk(4'h1, 16'h000B, 16'h0000, 16'h0000, 4'h1, 4'h0, 16'h0000, 1, 4'h0, 0,  0, 2'b11));
      vecs.push_back(mk(4'h0, 16'h0005, 16'h0000, 16'h0000, 4'h1, 4'h0, 16'h0000, 0, 4'h0, 0,  0, 2'b11));
      vecs.push_back(mk(4'hF, 16'h1234, 16'h0000, 16'h0000, 4'h5, 4'h0, 16'h0000, 0, 4'h0, 2,  0, 2'b11));
      vecs.push_back(mk(4'hA, 16'hFFFF, 16'h0040, 16'h3000, 4'h0, 4'h0, 16'h0000, 0, 4'h2, 2,  0, 2'b11));

      drive_idle();
      rst = 1'b1;
      #12;
      check("reset occupancy", 32'(bus.occupancy), 32'd0);
      check("reset full", 32'(bus.full), 32'd0);
      check("reset err", 32'(bus.err), 32'd0);
      check("reset hazard", 32'(bus.hazard), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int k = 0; k < vecs.size(); k++) apply(k, vecs[k]);

      // Asynchronous reset asserted between clock edges
      @(negedge clk);
      drive_idle();
      @(posedge clk);
      #3;
      check("pre-rst occupancy", 32'(bus.occupancy), 32'd2);
      rst = 1'b1;
      #1;
      check("async rst occupancy", 32'(bus.occupancy), 32'd0);
      check("async rst err", 32'(bus.err), 32'd0);
      check("async rst full", 32'(bus.full), 32'd0);
      #1;
      rst = 1'b0;

      // Still operational after the async reset; old entries are gone
      apply(100, mk(4'h1, 16'h0005, 16'h0004, 16'h0002, 4'h1, 4'h0, 16'h0000, 0, 4'h0, 1, 0, 2'b00));
      apply(101, mk(4'h2, 16'h0000, 16'h0050, 16'h0000, 4'h0, 4'h0, 16'h0000, 0, 4'h2, 1, 0, 2'b00));

      @(negedge clk);
      drive_idle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
